modmul_operand_loader: RTL and testbench

//  Upstream feeder for the OM-Pipe Multiplier.
//  - Accepts operand pairs (a then b) as a W-bit valid/ready word stream.
//  - Assembles them into a double-buffered shadow register.
//  - Presents a, b stable for exactly one multiplier slot of N_CYCLES clocks.
//  - Emits an issue pulse marking each slot that carries a new pair.
//  - Modulus constants (r, rn, rm, rx1..rx3, k) are outside this block.

---
 rtl/modmul_operand_loader.sv | 107 ++++++++++
 tb/tb_modmul_operand_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_operand_loader.sv
// Operand loader: assembles a/b pairs from a word stream into a shadow register and
// swaps them onto the multiplier inputs at slot boundaries. Optional: MODMUL_LOADER_STATS_EN.
module modmul_operand_loader #(
    parameter int N        = 512,
    parameter int W        = 64,
    parameter int N_STAGES = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic [N-1:0]     out_a,
    output logic [N-1:0]     out_b,
    output logic             out_valid,
    output logic             out_issue,
    output logic [15:0]      out_bubbles
);

    localparam int N_CYCLES   = N / (N_STAGES - 2) + 2;
    localparam int WORDS      = N / W;
    localparam int PAIR_WORDS = 2 * WORDS;
    localparam int CNT_W      = (PAIR_WORDS > 1) ? $clog2(PAIR_WORDS) : 1;
    localparam int SLOT_W     = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(PAIR_WORDS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_CYCLES - 1);

    logic [CNT_W-1:0]  word_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [N-1:0]      shadow_a_p0;
    logic [N-1:0]      shadow_b_p0;
    logic              shadow_full_p0;
    logic              accept;
    logic              slot_end;

    assign s_ready  = !shadow_full_p0;
    assign accept   = s_valid && s_ready;
    assign slot_end = (slot_cnt == SLOT_LAST);

    // Stage p0: word assembly into the shadow pair
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_cnt       <= '0;
            shadow_a_p0    <= '0;
            shadow_b_p0    <= '0;
            shadow_full_p0 <= 1'b0;
        end else begin
            if (accept) begin
                word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
                for (int i = 0; i < WORDS; i++) begin
                    if (word_cnt == CNT_W'(i))
                        shadow_a_p0[i*W +: W] <= s_data;
                    if (word_cnt == CNT_W'(i + WORDS))
                        shadow_b_p0[i*W +: W] <= s_data;
                end
            end
            // Acceptance and swap are mutually exclusive because s_ready is low while full
            if (accept && word_cnt == WORD_LAST)
                shadow_full_p0 <= 1'b1;
            else if (slot_end && shadow_full_p0)
                shadow_full_p0 <= 1'b0;
        end
    end

    // Stage p1: slot timing and operand swap onto the multiplier inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_cnt  <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
            out_issue <= 1'b0;
        end else begin
            slot_cnt  <= slot_end ? '0 : slot_cnt + 1'b1;
            out_issue <= slot_end && shadow_full_p0;
            if (slot_end) begin
                if (shadow_full_p0) begin
                    out_a     <= shadow_a_p0;
                    out_b     <= shadow_b_p0;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef MODMUL_LOADER_STATS_EN
    logic [15:0] bubbles;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            bubbles <= 16'h0000;
        else if (slot_end && !shadow_full_p0)
            bubbles <= sat_inc16(bubbles);
    end

    assign out_bubbles = bubbles;
`else
    assign out_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_modmul_operand_loader.sv
// Bench for modmul_operand_loader: pair-level reference model, directed slot-timing
// sequences, a table of operand pairs and a randomized stream.
module tb_modmul_operand_loader;

    localparam int N     = 16;
    localparam int W     = 8;
    localparam int NST   = 3;
    localparam int NC    = N / (NST - 2) + 2;
    localparam int WORDS = N / W;
    localparam int PW    = 2 * WORDS;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic [N-1:0] out_a, out_b;
    logic         out_valid, out_issue;
    logic [15:0]  out_bubbles;

    modmul_operand_loader #(.N(N), .W(W), .N_STAGES(NST)) dut (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
        .out_issue(out_issue), .out_bubbles(out_bubbles)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words queue into a pair; a completed pair waits for the next slot end
    int           cyc;
    logic [W-1:0] wq[$];
    logic         full;
    logic [N-1:0] sh_a, sh_b, m_a, m_b;
    logic         m_valid, m_issue;
    int           m_bub;
    logic         accepted;
    int           iss_q[$];
    logic [N-1:0] iss_a, iss_b;

    typedef struct {
        logic [W-1:0] w[PW];
        logic [N-1:0] a;
        logic [N-1:0] b;
    } vec_t;
    vec_t tv[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; wq.delete(); full = 1'b0;
        sh_a = '0; sh_b = '0; m_a = '0; m_b = '0;
        m_valid = 1'b0; m_issue = 1'b0; m_bub = 0;
        iss_q.delete();
    endtask

    // Called at a falling edge; drives inputs, checks outputs, advances the model one clock
    task automatic cycle(input logic v, input logic [W-1:0] d);
        logic slot_end;
        s_valid = v; s_data = d;
        #1;
        check("s_ready",   32'(s_ready),   32'(!full));
        check("out_a",     32'(out_a),     32'(m_a));
        check("out_b",     32'(out_b),     32'(m_b));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_issue", 32'(out_issue), 32'(m_issue));
        check("bubbles",   32'(out_bubbles), 32'(m_bub));
        if (out_issue === 1'b1) begin
            iss_q.push_back(cyc); iss_a = out_a; iss_b = out_b;
        end
        accepted = v && !full;
        slot_end = (cyc % NC) == NC - 1;
        m_issue = 1'b0;
        if (slot_end) begin
            if (full) begin
                m_a = sh_a; m_b = sh_b; m_valid = 1'b1; m_issue = 1'b1; full = 1'b0;
            end else begin
                m_valid = 1'b0;
`ifdef MODMUL_LOADER_STATS_EN
                if (m_bub < 16'hFFFF) m_bub++;
`endif
            end
        end
        if (accepted) begin
            wq.push_back(d);
            if (wq.size() == PW) begin
                for (int i = 0; i < WORDS; i++) begin
                    sh_a[i*W +: W] = wq[i];
                    sh_b[i*W +: W] = wq[WORDS + i];
                end
                wq.delete();
                full = 1'b1;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic send_word(input logic [W-1:0] d);
        int tries;
        tries = 0;
        accepted = 1'b0;
        while (!accepted && tries < 3 * NC) begin
            cycle(1'b1, d);
            tries++;
        end
        if (!accepted) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout cyc=%0d got=stalled want=accepted", cyc);
        end
    endtask

    task automatic idle_until(input int c);
        while (cyc < c) cycle(1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; s_valid = 1'b0;
        #1;
        check("rst_s_ready",   32'(s_ready),   32'd1);
        check("rst_out_a",     32'(out_a),     32'd0);
        check("rst_out_b",     32'(out_b),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_issue", 32'(out_issue), 32'd0);
        check("rst_bubbles",   32'(out_bubbles), 32'd0);
        repeat (n) @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        tv[0].w = '{8'h34, 8'h12, 8'h78, 8'h56}; tv[0].a = 16'h1234; tv[0].b = 16'h5678;
        tv[1].w = '{8'hBC, 8'h9A, 8'hF0, 8'hDE}; tv[1].a = 16'h9ABC; tv[1].b = 16'hDEF0;
        tv[2].w = '{8'h00, 8'h00, 8'hFF, 8'hFF}; tv[2].a = 16'h0000; tv[2].b = 16'hFFFF;
        tv[3].w = '{8'hFF, 8'hFF, 8'h01, 8'h00}; tv[3].a = 16'hFFFF; tv[3].b = 16'h0001;
        model_reset();

        @(negedge clock);
        do_reset(5);

        // Single pair sent in cycles 1-4: issued at cycle 18, bubble slot afterwards
        cycle(1'b0, '0);
        send_word(8'h34); send_word(8'h12); send_word(8'h78); send_word(8'h56);
        idle_until(2 * NC + 4);
        check("t2_issue_cnt", 32'(iss_q.size()), 32'd1);
        if (iss_q.size() > 0) check("t2_issue_cyc", 32'(iss_q[0]), 32'd18);
        check("t2_a", 32'(iss_a), 32'h1234);
        check("t2_b", 32'(iss_b), 32'h5678);

        // Back-to-back pairs: second issue exactly one slot after the first
        do_reset(2);
        cycle(1'b0, '0);
        send_word(8'h34); send_word(8'h12); send_word(8'h78); send_word(8'h56);
        check("t3_stall", 32'(s_ready), 32'd0);
        send_word(8'hBC); send_word(8'h9A); send_word(8'hF0); send_word(8'hDE);
        idle_until(3 * NC);
        check("t3_issue_cnt", 32'(iss_q.size()), 32'd2);
        if (iss_q.size() > 1) check("t3_issue_gap", 32'(iss_q[1] - iss_q[0]), 32'(NC));
        check("t3_a", 32'(iss_a), 32'h9ABC);
        check("t3_b", 32'(iss_b), 32'hDEF0);

        // Last word lands on the slot-end cycle: swap deferred to cycle 36
        do_reset(2);
        idle_until(NC - 4);
        send_word(8'h01); send_word(8'h02); send_word(8'h03); send_word(8'h04);
        idle_until(3 * NC);
        check("t4_issue_cnt", 32'(iss_q.size()), 32'd1);
        if (iss_q.size() > 0) check("t4_issue_cyc", 32'(iss_q[0]), 32'(2 * NC));

        // Reset after a partial pair discards the stale words
        do_reset(2);
        send_word(8'hAA); send_word(8'hBB); send_word(8'hCC);
        do_reset(3);
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        idle_until(2 * NC);
        check("t5_issue_cnt", 32'(iss_q.size()), 32'd1);
        check("t5_a", 32'(iss_a), 32'h2211);
        check("t5_b", 32'(iss_b), 32'h4433);

        // Idle for three slots
        do_reset(2);
        idle_until(3 * NC + 1);
`ifdef MODMUL_LOADER_STATS_EN
        check("t6_bubbles", 32'(out_bubbles), 32'd3);
`else
        check("t6_bubbles", 32'(out_bubbles), 32'd0);
`endif

        // Table of operand pairs
        for (int k = 0; k < 4; k++) begin
            int n0, lim;
            n0 = iss_q.size();
            for (int j = 0; j < PW; j++) send_word(tv[k].w[j]);
            lim = cyc + 3 * NC;
            while (iss_q.size() == n0 && cyc < lim) cycle(1'b0, '0);
            check("tv_issued", 32'(iss_q.size()), 32'(n0 + 1));
            check("tv_a", 32'(iss_a), 32'(tv[k].a));
            check("tv_b", 32'(iss_b), 32'(tv[k].b));
        end

        // Randomized stream against the model
        for (int r = 0; r < 600; r++)
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom));

        // Asynchronous reset mid-slot clears everything immediately
        do_reset(2);
        idle_until(NC + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
